// File: rtl/ascon_pack.sv
// rtl/ascon_pack.sv - shared types and constants for the Ascon permutation control path
package ascon_pack;

    localparam int NB_ROUNDS_MAX = 12;
    localparam int ROUND_W       = 4;

    // Every run ends on this constant index, whatever its length.
    localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(NB_ROUNDS_MAX - 1);

    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_RUN,
        SEQ_DONE
    } type_seq_state;

    // A run of n rounds uses the last n round constants.
    function automatic logic [ROUND_W-1:0] first_round(input int n);
        return ROUND_W'(NB_ROUNDS_MAX - n);
    endfunction

endpackage

// File: rtl/perm_round_counter.sv
// rtl/perm_round_counter.sv - loadable round-constant index counter that saturates at the last round
//   clock      in   rising-edge clock
//   reset      in   synchronous active-high reset, clears count
//   load       in   capture load_value (priority over enable)
//   load_value in   first round index of the run
//   enable     in   advance by one; holds once the last round is reached
//   count      out  current round index
//   last       out  count is the final round index
module perm_round_counter
    import ascon_pack::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               load,
    input  logic [ROUND_W-1:0] load_value,
    input  logic               enable,
    output logic [ROUND_W-1:0] count,
    output logic               last
);

    assign last = (count == LAST_ROUND);

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable && !last) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/permutation_sequencer.sv
// rtl/permutation_sequencer.sv - round sequencer for the iterative Ascon permutation (p^a / p^b)
//   clock_i         in   rising-edge clock
//   reset_i         in   synchronous active-high reset
//   start_i         in   run request, taken while ready_o=1
//   pb_sel_i        in   0: p^a (ROUNDS_A), 1: p^b (ROUNDS_B), taken with start_i
//   abort_i         in   cancel the run in progress (only with PERM_SEQ_ABORT_EN)
//   ready_o         out  idle or done, start_i accepted this cycle
//   busy_o          out  rounds in progress
//   done_o          out  one-cycle pulse, state register holds the result
//   round_o         out  round-constant index
//   input_select_o  out  1: datapath loads external state, 0: feedback
//   ena_reg_state_o out  state register write enable
// Optional feature macro: PERM_SEQ_ABORT_EN
module permutation_sequencer
    import ascon_pack::*;
#(
    parameter int ROUNDS_A = 12,
    parameter int ROUNDS_B = 6
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic               start_i,
    input  logic               pb_sel_i,
`ifdef PERM_SEQ_ABORT_EN
    input  logic               abort_i,
`endif
    output logic               ready_o,
    output logic               busy_o,
    output logic               done_o,
    output logic [ROUND_W-1:0] round_o,
    output logic               input_select_o,
    output logic               ena_reg_state_o
);

    if (!(ROUNDS_B >= 1 && ROUNDS_B <= ROUNDS_A && ROUNDS_A <= NB_ROUNDS_MAX)) begin : g_bad_rounds
        $error("permutation_sequencer: need 1 <= ROUNDS_B <= ROUNDS_A <= 12");
    end

    localparam logic [ROUND_W-1:0] FIRST_A = first_round(ROUNDS_A);
    localparam logic [ROUND_W-1:0] FIRST_B = first_round(ROUNDS_B);

    type_seq_state state;
    logic          first_cycle;
    logic          accept;
    logic          abort;
    logic          last;
    logic          cnt_enable;

`ifdef PERM_SEQ_ABORT_EN
    assign abort = abort_i;
`else
    assign abort = 1'b0;
`endif

    assign accept     = (state != SEQ_RUN) && start_i;
    // Freeze the index on abort so round_o keeps showing where the run stopped.
    assign cnt_enable = (state == SEQ_RUN) && !abort;

    perm_round_counter u_round_counter (
        .clock      (clock_i),
        .reset      (reset_i),
        .load       (accept),
        .load_value (pb_sel_i ? FIRST_B : FIRST_A),
        .enable     (cnt_enable),
        .count      (round_o),
        .last       (last)
    );

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state       <= SEQ_IDLE;
            first_cycle <= 1'b0;
        end else begin
            case (state)
                SEQ_IDLE: begin
                    if (start_i) begin
                        state       <= SEQ_RUN;
                        first_cycle <= 1'b1;
                    end
                end
                SEQ_RUN: begin
                    first_cycle <= 1'b0;
                    if (abort) begin
                        state <= SEQ_IDLE;
                    end else if (last) begin
                        state <= SEQ_DONE;
                    end
                end
                SEQ_DONE: begin
                    if (start_i) begin
                        state       <= SEQ_RUN;
                        first_cycle <= 1'b1;
                    end else begin
                        state <= SEQ_IDLE;
                    end
                end
                default: begin
                    state       <= SEQ_IDLE;
                    first_cycle <= 1'b0;
                end
            endcase
        end
    end

    assign ready_o         = (state == SEQ_IDLE) || (state == SEQ_DONE);
    assign busy_o          = (state == SEQ_RUN);
    assign done_o          = (state == SEQ_DONE);
    assign ena_reg_state_o = (state == SEQ_RUN);
    // Outside RUN the mux rests on the external state, ready for the next load.
    assign input_select_o  = (state != SEQ_RUN) || first_cycle;

endmodule
